// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and its instruction buffer.
package cpu_pkg;

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_DROP} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction buffer between fetch and decode; flush beats push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rptr, wptr;
  logic            do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem handshake, redirect flush, buffered
// {instr, pc+4} toward decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  input  logic        id_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d, out_addr_q, out_addr_d;
  logic          run_q;
  logic          push, pop, empty, full;
  logic [CW-1:0] count;
  fetch_entry_t  head, wentry;

  // run_q holds the request low during and for the first edge after reset
  assign imem_req  = run_q && (state_q == F_REQ) && (count < CW'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign if_valid  = !empty;
  assign if_instr  = head.instr;
  assign if_pc4    = head.pc4;
  assign pop       = if_valid && id_ready && !redirect;
  assign wentry    = '{instr: imem_rdata, pc4: out_addr_q + PC_INC};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_addr_d = out_addr_q;
    push       = 1'b0;
    unique case (state_q)
      F_REQ: begin
        if (imem_req && imem_gnt) begin
          out_addr_d = pc_q;
          pc_d       = pc_q + PC_INC;
          state_d    = redirect ? F_DROP : F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect && (!full || pop);
          state_d = F_REQ;
        end else if (redirect) begin
          state_d = F_DROP;
        end
      end
      F_DROP: begin
        if (imem_rvalid) state_d = F_REQ;
      end
      default: state_d = F_REQ;
    endcase
    if (redirect) pc_d = redirect_pc & ~32'h3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= F_REQ;
      pc_q       <= RESET_PC;
      out_addr_q <= RESET_PC;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_addr_q <= out_addr_d;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit; a queue-based model tracks the expected
// fetch address stream and the decode-side instruction buffer.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid, redirect, if_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc4;

  // second instance: wrap-around reset PC, memory always grants, data next cycle
  logic        req2, rv2, valid2;
  logic        gnt2 = 1'b1, redir2 = 1'b0, rdy2 = 1'b1;
  logic [31:0] addr2, rdata2, instr2, pc42;
  logic [31:0] rpc2 = 32'h0;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc4(if_pc4), .id_ready(id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(gnt2), .imem_rvalid(rv2), .imem_rdata(rdata2),
    .redirect(redir2), .redirect_pc(rpc2), .if_valid(valid2),
    .if_instr(instr2), .if_pc4(pc42), .id_ready(rdy2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv2    <= 1'b0;
      rdata2 <= '0;
    end else begin
      rv2    <= req2 && gnt2;
      rdata2 <= mem_word(addr2);
    end
  end

  int vectors = 0;
  int errs    = 0;

  fetch_entry_t q[$];
  logic [31:0]  gaddr[$];
  logic [31:0]  popq[$];
  logic [31:0]  g2addr[$];
  logic [31:0]  first2;
  bit           have2 = 0;
  bit           pend = 0, pend_drop = 0, started = 0;
  logic [31:0]  pend_addr = '0, exp_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare registered outputs, advance the model.
  task automatic cycle(input bit gnt_en, input int rv_pct, input bit rdy,
                       input bit redir, input logic [31:0] rpc);
    bit g, rv;
    logic [31:0] d;
    fetch_entry_t e;
    @(negedge clk);
    g  = imem_req && gnt_en;
    rv = pend && ($urandom_range(99) < rv_pct);
    d  = rv ? mem_word(pend_addr) : $urandom;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = d;
    id_ready = rdy; redirect = redir; redirect_pc = redir ? rpc : $urandom;
    #1;
    chk("if_valid", 32'(if_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_instr", if_instr, q[0].instr);
      chk("if_pc4", if_pc4, q[0].pc4);
    end
    chk("imem_req", 32'(imem_req), 32'(started && !pend && q.size() < DEPTH));
    if (started && !pend && q.size() < DEPTH) chk("imem_addr", imem_addr, exp_pc);
    if (req2 && gnt2 && g2addr.size() < 2) g2addr.push_back(addr2);
    if (valid2 && !have2) begin first2 = pc42; have2 = 1; end
    if (q.size() != 0 && rdy && !redir) begin
      popq.push_back(if_pc4);
      void'(q.pop_front());
    end
    if (rv) begin
      if (!pend_drop && !redir) begin
        e.instr = d; e.pc4 = pend_addr + 32'd4;
        q.push_back(e);
      end
      pend = 0;
    end
    if (g) begin
      pend = 1; pend_drop = redir; pend_addr = imem_addr;
      exp_pc = imem_addr + 32'd4;
      gaddr.push_back(imem_addr);
    end
    if (redir) begin
      q.delete();
      if (pend) pend_drop = 1;
      exp_pc = rpc & ~32'h3;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    imem_gnt = 0; imem_rvalid = 0; redirect = 0;
    q.delete(); gaddr.delete(); popq.delete();
    pend = 0; pend_drop = 0; started = 0; exp_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    started = 1;
  endtask

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; id_ready = 0;

    // reset, then back-to-back fetch with immediate grant and data
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 100, 1, 0, 0);
    chk("seq_a0", gaddr.size() > 0 ? gaddr[0] : 32'hDEAD_BEEF, 32'h0);
    chk("seq_a1", gaddr.size() > 1 ? gaddr[1] : 32'hDEAD_BEEF, 32'h4);
    chk("seq_a2", gaddr.size() > 2 ? gaddr[2] : 32'hDEAD_BEEF, 32'h8);
    chk("seq_p0", popq.size() > 0 ? popq[0] : 32'hDEAD_BEEF, 32'h4);
    chk("seq_p1", popq.size() > 1 ? popq[1] : 32'hDEAD_BEEF, 32'h8);
    chk("seq_p2", popq.size() > 2 ? popq[2] : 32'hDEAD_BEEF, 32'hC);

    // decode stalled: buffer fills with two entries, request stops
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 100, 0, 0, 0);
    chk("stall_ngnt", 32'(gaddr.size()), 32'd2);
    chk("stall_req", 32'(imem_req), 32'h0);
    chk("stall_valid", 32'(if_valid), 32'h1);
    for (int i = 0; i < 8; i++) cycle(1, 100, 1, 0, 0);
    chk("stall_p0", popq.size() > 0 ? popq[0] : 32'hDEAD_BEEF, 32'h4);
    chk("stall_p1", popq.size() > 1 ? popq[1] : 32'hDEAD_BEEF, 32'h8);
    chk("stall_resume", gaddr.size() > 2 ? gaddr[2] : 32'hDEAD_BEEF, 32'h8);

    // redirect while waiting on read data
    for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, 1, 0, 0);
    chk("wait_reached", 32'(pend), 32'h1);
    begin
      int gi, pi;
      gi = gaddr.size(); pi = popq.size();
      cycle(0, 0, 1, 1, 32'h0000_0102);
      for (int i = 0; i < 10; i++) cycle(1, 100, 1, 0, 0);
      chk("rw_addr", gaddr.size() > gi ? gaddr[gi] : 32'hDEAD_BEEF, 32'h100);
      chk("rw_pc4", popq.size() > pi ? popq[pi] : 32'hDEAD_BEEF, 32'h104);
    end

    // redirect in the same cycle as the grant for 0x10
    for (int i = 0; i < 20 && pend; i++) cycle(0, 100, 1, 0, 0);
    cycle(0, 100, 1, 1, 32'h10);
    begin
      int gi, pi;
      gi = gaddr.size(); pi = popq.size();
      cycle(1, 0, 1, 1, 32'h40);
      chk("rg_gaddr", gaddr.size() > gi ? gaddr[gi] : 32'hDEAD_BEEF, 32'h10);
      for (int i = 0; i < 10; i++) cycle(1, 100, 1, 0, 0);
      chk("rg_next", gaddr.size() > gi + 1 ? gaddr[gi+1] : 32'hDEAD_BEEF, 32'h40);
      chk("rg_pc4", popq.size() > pi ? popq[pi] : 32'hDEAD_BEEF, 32'h44);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(1)), int'($urandom_range(10, 100)), 1'($urandom_range(1)),
            $urandom_range(99) < 4, $urandom);

    // reset asserted while a read is outstanding
    for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, 1, 0, 0);
    chk("rst_wait_reached", 32'(pend), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 100, 1, 0, 0);
    chk("rst_first", gaddr.size() > 0 ? gaddr[0] : 32'hDEAD_BEEF, 32'h0);

    // wrap-around instance
    chk("wrap_a0", g2addr.size() > 0 ? g2addr[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_a1", g2addr.size() > 1 ? g2addr[1] : 32'hDEAD_BEEF, 32'h0);
    chk("wrap_pc4", have2 ? first2 : 32'hDEAD_BEEF, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
